// File: rtl/word_uart_pkg.sv
// Shared types, sizing helpers and parameter-legality checks for the word-to-UART serializer.
package word_uart_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    localparam int GAP_W   = 8;
    localparam int MAX_GAP = 255;

    function automatic int nbytes(input int word_w);
        return word_w / 8;
    endfunction

    function automatic int cnt_width(input int word_w);
        return $clog2(nbytes(word_w) + 1);
    endfunction

    function automatic bit word_w_ok(input int word_w);
        return (word_w % 8 == 0) && (word_w >= 8) && (word_w <= 64);
    endfunction

    function automatic bit gap_ok(input int gap);
        return (gap >= 0) && (gap <= MAX_GAP);
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry holding register for the word queued behind the active one.
module word_hold_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         full,
    output logic [W-1:0] data
);

    // A write in the same cycle as a read refills the entry, so it stays full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr_en) begin
            full <= 1'b1;
            data <= wr_data;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/word_uart_serializer.sv
// Splits WORD_W-bit words into bytes for a UART TX, one tx_en pulse per byte,
// pacing on tx_done with an optional idle gap between bytes.
module word_uart_serializer
    import word_uart_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              tx_done,
    output logic [7:0]        out_8,
    output logic              tx_en,
    output logic              busy,
    output logic              word_done
);

    localparam int NB = nbytes(WORD_W);
    localparam int CW = cnt_width(WORD_W);
    localparam logic [CW-1:0]    NB_C     = CW'(NB);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (!word_w_ok(WORD_W)) begin : g_bad_word_w
        $error("WORD_W must be a multiple of 8 in 8..64");
    end
    if (!gap_ok(GAP_CYCLES)) begin : g_bad_gap
        $error("GAP_CYCLES must be in 0..255");
    end

    function automatic logic [7:0] head(input logic [WORD_W-1:0] v);
        return MSB_FIRST ? v[WORD_W-1 -: 8] : v[7:0];
    endfunction

    function automatic logic [WORD_W-1:0] shift8(input logic [WORD_W-1:0] v);
        return MSB_FIRST ? (v << 8) : (v >> 8);
    endfunction

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CW-1:0]     bcnt;
    logic [GAP_W-1:0]  gcnt;

    logic              pend_full;
    logic [WORD_W-1:0] pend_word;
    logic              accept, last_done, take_pend, take_in, pend_wr;
    logic [WORD_W-1:0] next_word;

    assign in_ready  = !pend_full && !reset;
    assign accept    = in_valid && in_ready;
    assign last_done = (state == WAIT) && tx_done && (bcnt == ONE_C);
    assign take_pend = last_done && pend_full;
    // A word arriving as the last byte finishes with nothing pending goes straight to active.
    assign take_in   = accept && ((state == IDLE) || (last_done && !pend_full));
    assign pend_wr   = accept && !take_in;
    assign next_word = take_pend ? pend_word : in_word;

    word_hold_buf #(.W(WORD_W)) u_pend (
        .clk     (sys_clk),
        .reset   (reset),
        .wr_en   (pend_wr),
        .wr_data (in_word),
        .rd_en   (take_pend),
        .full    (pend_full),
        .data    (pend_word)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            out_8     <= '0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            tx_en     <= 1'b0;
            word_done <= 1'b0;
            busy      <= accept || pend_full || (state != IDLE);
            case (state)
                IDLE: begin
                    if (take_in) begin
                        shreg <= next_word;
                        bcnt  <= NB_C;
                        out_8 <= head(next_word);
                        tx_en <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (last_done) begin
                        word_done <= 1'b1;
                        if (take_pend || take_in) begin
                            shreg <= next_word;
                            bcnt  <= NB_C;
                            out_8 <= head(next_word);
                            tx_en <= 1'b1;
                            state <= SEND;
                        end else begin
                            bcnt  <= '0;
                            state <= IDLE;
                        end
                    end else if (tx_done) begin
                        bcnt  <= bcnt - 1'b1;
                        shreg <= shift8(shreg);
                        if (GAP_CYCLES == 0) begin
                            out_8 <= head(shift8(shreg));
                            tx_en <= 1'b1;
                            state <= SEND;
                        end else begin
                            gcnt  <= '0;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // out_8 keeps the previous byte until the next SEND.
                    if (gcnt == GAP_LAST) begin
                        out_8 <= head(shreg);
                        tx_en <= 1'b1;
                        state <= SEND;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_uart_serializer.sv
// Directed bench: four serializer configurations driven by a UART model that answers each tx_en with tx_done.
module tb_word_uart_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] w     [4];
    logic        v     [4];
    logic        stray [4];
    logic        md    [4];
    logic        td    [4];
    logic        rdy   [4];
    logic        te    [4];
    logic        bz    [4];
    logic        wd    [4];
    logic [7:0]  o8    [4];
    int          mcnt  [4];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int         bn [4], tn [4], wn [4], dbl [4];
    logic       pte [4];
    logic [7:0] bq  [4][32];
    int         tec [4][32];
    int         tdc [4][32];
    int         wdc [4][32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb for (int i = 0; i < 4; i++) td[i] = md[i] | stray[i];

    word_uart_serializer #(.WORD_W(32), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
        .sys_clk(clk), .reset(rst), .in_word(w[0]), .in_valid(v[0]), .in_ready(rdy[0]),
        .tx_done(td[0]), .out_8(o8[0]), .tx_en(te[0]), .busy(bz[0]), .word_done(wd[0]));
    word_uart_serializer #(.WORD_W(32), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
        .sys_clk(clk), .reset(rst), .in_word(w[1]), .in_valid(v[1]), .in_ready(rdy[1]),
        .tx_done(td[1]), .out_8(o8[1]), .tx_en(te[1]), .busy(bz[1]), .word_done(wd[1]));
    word_uart_serializer #(.WORD_W(16), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (
        .sys_clk(clk), .reset(rst), .in_word(w[2][15:0]), .in_valid(v[2]), .in_ready(rdy[2]),
        .tx_done(td[2]), .out_8(o8[2]), .tx_en(te[2]), .busy(bz[2]), .word_done(wd[2]));
    word_uart_serializer #(.WORD_W(32), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u3 (
        .sys_clk(clk), .reset(rst), .in_word(w[3]), .in_valid(v[3]), .in_ready(rdy[3]),
        .tx_done(td[3]), .out_8(o8[3]), .tx_en(te[3]), .busy(bz[3]), .word_done(wd[3]));

    // UART model: tx_done pulses roughly 10 cycles after each tx_en.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mcnt[i] <= 0;
                md[i]   <= 1'b0;
            end else begin
                md[i]   <= (mcnt[i] == 1);
                mcnt[i] <= te[i] ? 10 : ((mcnt[i] != 0) ? mcnt[i] - 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (te[i]) begin
                if (bn[i] < 32) begin
                    bq[i][bn[i]]  = o8[i];
                    tec[i][bn[i]] = cyc;
                end
                bn[i]++;
                if (pte[i]) dbl[i]++;
            end
            pte[i] = te[i];
            if (md[i]) begin
                if (tn[i] < 32) tdc[i][tn[i]] = cyc;
                tn[i]++;
            end
            if (wd[i]) begin
                if (wn[i] < 32) wdc[i][wn[i]] = cyc;
                wn[i]++;
            end
        end
    end

    task automatic clear_mon(input int i);
        bn[i] = 0; tn[i] = 0; wn[i] = 0; dbl[i] = 0;
    endtask

    task automatic send_word(input int i, input logic [31:0] val, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        w[i] = val;
        v[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (rdy[i]) begin
                acc = cyc;
                ok  = 1'b1;
                @(negedge clk);
                v[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        v[i] = 1'b0;
    endtask

    task automatic wait_wd(input int i, input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (wn[i] >= n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low: got %b want 0", rdy[0]); end
        n_cmp++; if (o8[0] !== 8'h00) begin n_bad++; $display("FAIL reset_out_8: got %h want 00", o8[0]); end
        n_cmp++; if (te[0] !== 1'b0) begin n_bad++; $display("FAIL reset_tx_en: got %b want 0", te[0]); end
        n_cmp++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bz[0]); end
        n_cmp++; if (wd[0] !== 1'b0) begin n_bad++; $display("FAIL reset_word_done: got %b want 0", wd[0]); end
        rst = 1'b0;
        #1;
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_after: got %b want 1", rdy[0]); end
        for (int i = 0; i < 4; i++) clear_mon(i);
    endtask

    task automatic run_word(input string name, input int i, input logic [31:0] val,
                            input int nbytes, input logic [7:0] exp [4]);
        int acc;
        bit ok, ok2;
        clear_mon(i);
        send_word(i, val, acc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept: no accept within bound", name); end
        n_cmp++; if (bz[i] !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", name, bz[i]); end
        wait_wd(i, 1, ok2);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok2) begin n_bad++; $display("FAIL %s_timeout: word_done never seen", name); end
        n_cmp++; if (bn[i] !== nbytes) begin n_bad++; $display("FAIL %s_nbytes: got %0d want %0d", name, bn[i], nbytes); end
        for (int k = 0; k < nbytes; k++) begin
            n_cmp++;
            if (bq[i][k] !== exp[k]) begin n_bad++; $display("FAIL %s_byte%0d: got %h want %h", name, k, bq[i][k], exp[k]); end
        end
        n_cmp++; if (tec[i][0] !== acc + 1) begin n_bad++; $display("FAIL %s_latency: tx_en cycle %0d want %0d", name, tec[i][0], acc + 1); end
        n_cmp++; if (dbl[i] !== 0) begin n_bad++; $display("FAIL %s_tx_en_width: %0d multi-cycle pulses want 0", name, dbl[i]); end
        n_cmp++; if (wn[i] !== 1) begin n_bad++; $display("FAIL %s_word_done_count: got %0d want 1", name, wn[i]); end
        n_cmp++; if (wdc[i][0] !== tdc[i][nbytes-1] + 1) begin n_bad++; $display("FAIL %s_word_done_cycle: got %0d want %0d", name, wdc[i][0], tdc[i][nbytes-1] + 1); end
        n_cmp++; if (bz[i] !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %b want 0", name, bz[i]); end
    endtask

    task automatic test_msb_first();
        logic [7:0] e [4];
        e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_word("msb32", 0, 32'hA1B2C3D4, 4, e);
    endtask

    task automatic test_lsb_first();
        logic [7:0] e [4];
        e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        run_word("lsb32", 1, 32'hA1B2C3D4, 4, e);
    endtask

    task automatic test_word16();
        logic [7:0] e [4];
        e = '{8'h55, 8'hAA, 8'h00, 8'h00};
        run_word("w16", 2, 32'h000055AA, 2, e);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [12];
        int rise;
        bit ok;
        e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        clear_mon(0);
        @(negedge clk);
        w[0] = 32'h11223344; v[0] = 1'b1;
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_w1: got %b want 1", rdy[0]); end
        @(negedge clk);
        w[0] = 32'h55667788;
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_w2: got %b want 1", rdy[0]); end
        @(negedge clk);
        w[0] = 32'h99AABBCC;
        n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b want 0", rdy[0]); end
        rise = -1;
        for (int k = 0; k < 400; k++) begin
            if (rdy[0]) begin rise = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        v[0] = 1'b0;
        n_cmp++; if (rise !== wdc[0][0]) begin n_bad++; $display("FAIL b2b_ready_return: cycle %0d want %0d", rise, wdc[0][0]); end
        wait_wd(0, 3, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: only %0d word_done", wn[0]); end
        n_cmp++; if (bn[0] !== 12) begin n_bad++; $display("FAIL b2b_nbytes: got %0d want 12", bn[0]); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (bq[0][k] !== e[k]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, bq[0][k], e[k]); end
        end
        n_cmp++; if (tec[0][4] !== tdc[0][3] + 1) begin n_bad++; $display("FAIL b2b_no_gap_w2: tx_en %0d want %0d", tec[0][4], tdc[0][3] + 1); end
        n_cmp++; if (tec[0][8] !== tdc[0][7] + 1) begin n_bad++; $display("FAIL b2b_no_gap_w3: tx_en %0d want %0d", tec[0][8], tdc[0][7] + 1); end
        n_cmp++; if (wn[0] !== 3) begin n_bad++; $display("FAIL b2b_word_done_count: got %0d want 3", wn[0]); end
    endtask

    task automatic test_gap();
        logic [7:0] e [4];
        e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_word("gap3", 3, 32'hA1B2C3D4, 4, e);
        for (int j = 1; j < 4; j++) begin
            n_cmp++;
            if (tec[3][j] - tdc[3][j-1] !== 4) begin
                n_bad++;
                $display("FAIL gap3_spacing%0d: tx_en-tx_done %0d want 4", j, tec[3][j] - tdc[3][j-1]);
            end
        end
    endtask

    task automatic test_stray();
        int acc;
        bit ok;
        clear_mon(0);
        @(negedge clk); stray[0] = 1'b1;
        @(negedge clk); stray[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bn[0] !== 0) begin n_bad++; $display("FAIL stray_idle_tx_en: %0d pulses want 0", bn[0]); end
        n_cmp++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL stray_idle_busy: got %b want 0", bz[0]); end
        n_cmp++; if (o8[0] !== 8'hCC) begin n_bad++; $display("FAIL stray_idle_out_8: got %h want cc", o8[0]); end
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL stray_idle_ready: got %b want 1", rdy[0]); end

        clear_mon(3);
        send_word(3, 32'h0A0B0C0D, acc, ok);
        for (int k = 0; k < 200 && tn[3] == 0; k++) @(negedge clk);
        @(negedge clk); stray[3] = 1'b1;
        @(negedge clk); stray[3] = 1'b0;
        n_cmp++; if (o8[3] !== 8'h0A) begin n_bad++; $display("FAIL stray_gap_out_8: got %h want 0a", o8[3]); end
        wait_wd(3, 1, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stray_gap_timeout: word_done never seen"); end
        n_cmp++; if (bn[3] !== 4) begin n_bad++; $display("FAIL stray_gap_nbytes: got %0d want 4", bn[3]); end
        n_cmp++; if (tec[3][1] - tdc[3][0] !== 4) begin n_bad++; $display("FAIL stray_gap_spacing: got %0d want 4", tec[3][1] - tdc[3][0]); end
        n_cmp++; if (bq[3][3] !== 8'h0D) begin n_bad++; $display("FAIL stray_gap_last_byte: got %h want 0d", bq[3][3]); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] e [4];
        int acc;
        bit ok;
        e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_mon(0);
        send_word(0, 32'hA1B2C3D4, acc, ok);
        for (int k = 0; k < 200 && tn[0] < 2; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_ready_low: got %b want 0", rdy[0]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (te[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_tx_en: got %b want 0", te[0]); end
        n_cmp++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bz[0]); end
        n_cmp++; if (o8[0] !== 8'h00) begin n_bad++; $display("FAIL midrst_out_8: got %h want 00", o8[0]); end
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_high: got %b want 1", rdy[0]); end
        run_word("midrst", 0, 32'hDEADBEEF, 4, e);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            w[i] = '0; v[i] = 1'b0; stray[i] = 1'b0; pte[i] = 1'b0;
            bn[i] = 0; tn[i] = 0; wn[i] = 0; dbl[i] = 0;
        end
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_word16();
        test_back_to_back();
        test_gap();
        test_stray();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
